// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight register writes after ID,
// drives the ID stall and per-read-port forward selects.
// Ports: clk, reset (async, active-low); ID request: id_valid, id_rs,
// id_wr_en, id_wr_reg, id_ready_stage; control: ext_hold, flush;
// outputs: stall, fwd_sel, stage_valid, stall_cycles.
module pipe_scoreboard #(
  parameter int AW      = 5,
  parameter int NSTAGES = 3,
  parameter int NPORTS  = 2,
  parameter int RSW     = 2,
  parameter int SELW    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [NPORTS*AW-1:0]   id_rs,
  input  logic                   id_wr_en,
  input  logic [AW-1:0]          id_wr_reg,
  input  logic [RSW-1:0]         id_ready_stage,
  input  logic                   ext_hold,
  input  logic                   flush,
  output logic                   stall,
  output logic [NPORTS*SELW-1:0] fwd_sel,
  output logic [NSTAGES-1:0]     stage_valid,
  output logic [15:0]            stall_cycles
);

  typedef struct packed {
    logic           v;
    logic [AW-1:0]  rg;
    logic [RSW-1:0] rdy;
  } entry_t;

  entry_t ent_q [NSTAGES];

  logic [NPORTS-1:0] port_stall;
  logic              bubble;

  always_comb begin
    logic [AW-1:0] r;
    int            ms;
    logic          hit;
    port_stall = '0;
    fwd_sel    = '0;
    r          = '0;
    ms         = 0;
    hit        = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      r   = id_rs[p*AW +: AW];
      ms  = 0;
      hit = 1'b0;
      // Scan oldest to youngest so the youngest match is what remains.
      for (int s = NSTAGES - 1; s >= 0; s--) begin
        if (ent_q[s].v && ent_q[s].rg == r) begin
          hit = 1'b1;
          ms  = s;
        end
      end
      if (id_valid && r != '0 && hit) begin
        if (ms >= int'(ent_q[ms].rdy))
          fwd_sel[p*SELW +: SELW] = SELW'(ms + 1);
        else
          port_stall[p] = 1'b1;
      end
    end
  end

  assign stall  = |port_stall;
  assign bubble = stall || flush || !id_valid ||
                  !id_wr_en || id_wr_reg == '0;

  always_comb begin
    for (int s = 0; s < NSTAGES; s++)
      stage_valid[s] = ent_q[s].v;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSTAGES; s++)
        ent_q[s] <= '0;
      stall_cycles <= '0;
    end else if (ext_hold) begin
      // Frozen pipe: only a flush may kill the EX occupant.
      if (flush)
        ent_q[0] <= '0;
    end else begin
      if (bubble)
        ent_q[0] <= '0;
      else
        ent_q[0] <= '{v: 1'b1, rg: id_wr_reg,
                      rdy: id_ready_stage};
      for (int s = 1; s < NSTAGES; s++)
        ent_q[s] <= ent_q[s-1];
      // The killed EX instruction must not retire.
      if (flush)
        ent_q[1] <= '0;
      if (stall && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard.
// Drives ID/control after each rising edge, checks before the next one.
module tb_pipe_scoreboard;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic        id_wr_en;
  logic [4:0]  id_wr_reg;
  logic [1:0]  id_ready_stage;
  logic        ext_hold;
  logic        flush;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [2:0]  stage_valid;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int errs    = 0;

  pipe_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_wr_en       (id_wr_en),
    .id_wr_reg      (id_wr_reg),
    .id_ready_stage (id_ready_stage),
    .ext_hold       (ext_hold),
    .flush          (flush),
    .stall          (stall),
    .fwd_sel        (fwd_sel),
    .stage_valid    (stage_valid),
    .stall_cycles   (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic id(input logic v, input logic [4:0] rs0,
                    input logic [4:0] rs1, input logic wen,
                    input logic [4:0] wr, input logic [1:0] rdy);
    id_valid       = v;
    id_rs          = {rs1, rs0};
    id_wr_en       = wen;
    id_wr_reg      = wr;
    id_ready_stage = rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    id(0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
  endtask

  initial begin
    reset    = 1'b0;
    ext_hold = 1'b0;
    flush    = 1'b0;
    id(0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_sv", 32'(stage_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd", 32'(fwd_sel), 0);
    chk("rst_cnt", 32'(stall_cycles), 0);
    cyc();
    reset = 1'b1;

    // ALU chain on $3
    cyc(); id(1, 0, 0, 1, 3, 0); #1;
    chk("alu_prod_stall", 32'(stall), 0);
    cyc(); id(1, 3, 0, 0, 0, 0); #1;
    chk("alu_sel1", 32'(fwd_sel), 4'h1);
    chk("alu_stall", 32'(stall), 0);
    cyc(); #1;
    chk("alu_sel2", 32'(fwd_sel), 4'h2);
    chk("alu_sv2", 32'(stage_valid), 3'b010);
    cyc(); #1;
    chk("alu_sel3", 32'(fwd_sel), 4'h3);
    chk("alu_sv3", 32'(stage_valid), 3'b100);
    cyc(); #1;
    chk("alu_sel0", 32'(fwd_sel), 4'h0);
    chk("alu_sv0", 32'(stage_valid), 3'b000);

    // Load-use on $5 read through port 1
    cyc(); id(1, 0, 0, 1, 5, 1); #1;
    chk("lu_prod_stall", 32'(stall), 0);
    cyc(); id(1, 0, 5, 1, 6, 0); #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_fwd_stall", 32'(fwd_sel), 0);
    cyc(); #1;
    chk("lu_release", 32'(stall), 0);
    chk("lu_sel", 32'(fwd_sel), 4'h8);
    chk("lu_bubble", 32'(stage_valid), 3'b010);
    chk("lu_cnt", 32'(stall_cycles), 1);
    cyc(); id(0, 0, 0, 0, 0, 0); #1;
    chk("lu_sv", 32'(stage_valid), 3'b101);
    drain();
    chk("lu_drain", 32'(stage_valid), 0);

    // Youngest match wins on $4
    id(1, 0, 0, 1, 4, 0);
    cyc(); id(1, 0, 0, 1, 4, 1); #1;
    chk("yw_lw_stall", 32'(stall), 0);
    cyc(); id(1, 4, 0, 0, 0, 0); #1;
    chk("yw_stall", 32'(stall), 1);
    chk("yw_fwd0", 32'(fwd_sel), 0);
    cyc(); #1;
    chk("yw_stall2", 32'(stall), 0);
    chk("yw_sel", 32'(fwd_sel), 4'h2);
    chk("yw_cnt", 32'(stall_cycles), 2);
    drain();

    // Register zero and non-writers never occupy an entry
    id(1, 0, 0, 1, 0, 0);
    cyc(); id(1, 0, 0, 0, 9, 0); #1;
    chk("z_sv1", 32'(stage_valid), 0);
    chk("z_stall", 32'(stall), 0);
    chk("z_fwd", 32'(fwd_sel), 0);
    cyc(); id(1, 0, 9, 0, 0, 0); #1;
    chk("z_sv2", 32'(stage_valid), 0);
    chk("z_fwd2", 32'(fwd_sel), 0);
    drain();

    // Flush kills load in EX
    id(1, 0, 0, 1, 7, 1);
    cyc(); id(0, 0, 0, 0, 0, 0); flush = 1'b1; #1;
    chk("fl_pre_sv", 32'(stage_valid), 3'b001);
    cyc(); flush = 1'b0; id(1, 7, 0, 0, 0, 0); #1;
    chk("fl_sv", 32'(stage_valid), 0);
    chk("fl_fwd", 32'(fwd_sel), 0);
    chk("fl_stall", 32'(stall), 0);

    // Hold with a load-use stall pending
    id(1, 0, 0, 1, 8, 0);
    cyc(); id(1, 0, 0, 1, 10, 1);
    cyc(); id(1, 0, 10, 1, 11, 0); #1;
    chk("h_stall", 32'(stall), 1);
    ext_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("h_sv", 32'(stage_valid), 3'b011);
      chk("h_stall_held", 32'(stall), 1);
      chk("h_cnt", 32'(stall_cycles), 2);
    end
    ext_hold = 1'b0;
    cyc(); #1;
    chk("h_rel_cnt", 32'(stall_cycles), 3);
    chk("h_rel_sv", 32'(stage_valid), 3'b110);
    chk("h_rel_sel", 32'(fwd_sel), 4'h8);
    cyc(); id(0, 0, 0, 0, 0, 0);
    ext_hold = 1'b1; flush = 1'b1; #1;
    chk("hf_pre", 32'(stage_valid), 3'b101);
    cyc(); #1;
    chk("hf_sv", 32'(stage_valid), 3'b100);
    chk("hf_cnt", 32'(stall_cycles), 3);
    ext_hold = 1'b0; flush = 1'b0;
    drain();

    // Mid-run async reset with three live entries
    id(1, 0, 0, 1, 1, 0);
    cyc(); id(1, 0, 0, 1, 2, 0);
    cyc(); id(1, 0, 0, 1, 3, 0);
    cyc(); id(1, 1, 0, 0, 0, 0); #1;
    chk("mr_pre_sv", 32'(stage_valid), 3'b111);
    chk("mr_pre_sel", 32'(fwd_sel), 4'h3);
    #2 reset = 1'b0;
    #1;
    chk("mr_sv", 32'(stage_valid), 0);
    chk("mr_stall", 32'(stall), 0);
    chk("mr_fwd", 32'(fwd_sel), 0);
    chk("mr_cnt", 32'(stall_cycles), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised hazard/forwarding scoreboard for the pipelined MIPS core.
- Replaces the fixed two-stage forwarding and load-use/branch hazard units.
- Tracks every in-flight register write in the NSTAGES stages after ID, with a per-instruction result-ready stage, so ALU, load and multi-cycle ops share one mechanism.
- Drives the ID stall (holds PC and IF/ID, inserts an EX bubble) and per-read-port forward selects consumed by ID and EX forward muxes.

Parameters:
AW, 5, register index width (NREGS = 2**AW)
NSTAGES, 3, tracked stages after ID (index 0 = EX, NSTAGES-1 = WB)
NPORTS, 2, ID read ports (rs, rt)
RSW, 2, width of ready-stage field
SELW, 2, forward select width; must satisfy 2**SELW > NSTAGES

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  NPORTS*AW  source register indices, port p at [p*AW +: AW]
id_wr_en  in  1  ID instruction writes a register
id_wr_reg  in  AW  destination register
id_ready_stage  in  RSW  stage index at whose output the result is first valid (0 ALU, 1 load, 2 mul)
ext_hold  in  1  global freeze (memory wait); scoreboard does not advance
flush  in  1  kill ID and EX occupants (taken branch or jump)
stall  out  1  ID must hold; bubble enters EX
fwd_sel  out  NPORTS*SELW  per-port select: 0 register file, k forward from stage k-1 output
stage_valid  out  NSTAGES  debug: entry valid and writes a register
stall_cycles  out  16  count of cycles with stall=1 and ext_hold=0; saturates at 0xFFFF

Behaviour:
- State: NSTAGES entries {v, reg, rdy}. Entry s = instruction in stage s.
- Reset (reset=0, async): all entries v=0; stall_cycles=0. stall=0 and fwd_sel=0 follow combinationally.
- Mid-operation reset clears all entries immediately, without waiting for clk.
- Hazard check, combinational, per port p with r = id_rs[p]:
  - r==0 or id_valid=0: sel=0, no stall contribution.
  - Otherwise find the smallest s with v && reg==r. Only this youngest match is considered; older matches are ignored.
  - No match: sel=0.
  - Match and s >= rdy: sel=s+1. A WB match (s=NSTAGES-1) forwards, because the register file is not write-through.
  - Match and s < rdy: port stalls, sel=0.
- stall = OR of all port stalls.
- Advance on rising clk when ext_hold=0:
  - entry[0] <= bubble (v=0) if stall or flush or !id_valid or !id_wr_en or id_wr_reg==0.
  - Otherwise entry[0] <= {1, id_wr_reg, id_ready_stage}.
  - entry[s] <= entry[s-1] for s >= 1, except entry[1] <= bubble when flush=1 (the killed EX instruction does not retire).
  - Oldest entry drops off the end.
- ext_hold=1:
  - All entries hold, and outputs stay consistent with held state.
  - stall_cycles does not count.
  - If flush=1 during hold, entry[0] is cleared and all other entries hold.
- flush and stall together: flush wins; entry[0] becomes a bubble either way.
- Latency: a producer enters entry[0] one edge after its ID cycle. A dependent instruction in ID on the next cycle sees it at s=0.
- Load-use (rdy=1): exactly one stall cycle. Mul (rdy=2): two stall cycles, then forward from stage 2.
- stall_cycles increments by 1 per qualifying edge and holds at 0xFFFF.

Test Plan:
- Reset: assert reset=0 mid-run with 3 valid entries -> stage_valid=000, stall=0, fwd_sel=0, stall_cycles=0 before the next edge.
- ALU chain: add $3 (rdy=0), then ID reads rs=$3 -> fwd_sel[port0]=1, stall=0. One cycle later, with a non-writer between -> sel=2. Then sel=3. Then sel=0.
- Load-use: lw $5 (rdy=1), next ID reads rt=$5 -> stall=1 for exactly 1 cycle, bubble in entry[0], then sel[port1]=2. stall_cycles=1.
- Youngest wins: addi $4 (rdy=0), then lw $4 (rdy=1), then ID reads $4 -> stall=1 (older addi ignored). Next cycle sel=2.
- Register zero / no-write: producer writes $0 or id_wr_en=0, consumer reads $0 -> stall=0, sel=0, entry[0] v=0.
- Flush + hold: lw $7 in EX, flush=1 -> entry[1] bubble, so a later read of $7 gives sel=0. With ext_hold=1 for 4 cycles, entries frozen and stall_cycles unchanged.
